// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one single-port RAM between the instruction-fetch port (I)
//            and the load/store port (D). One access is granted per cycle using
//            a combinational req/gnt handshake. Read data is registered and
//            returned one cycle after the grant together with an rvalid pulse.
// Ports    : clk, rst_n              clock, asynchronous active-low reset
//            i_req/i_addr            I read request and word address
//            i_gnt/i_rvalid/i_rdata  I grant, response pulse, read data
//            d_req/d_we/d_addr       D request, write enable, word address
//            d_wdata/d_strobe        D write data and byte-lane strobe
//            d_gnt/d_rvalid/d_rdata  D grant, response pulse, read data
//            ram_*                   single-port RAM macro interface
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DBUS_PRIORITY = 1,
    parameter int MAX_WAIT      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_strobe,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wr_data,
    output logic [3:0]            ram_wr_strobe,
    input  logic [31:0]           ram_rd_data
);

    localparam int                WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic              LAST_I   = 1'b0;
    localparam logic              LAST_D   = 1'b1;

    logic              last_q;
    logic              last_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              i_rvalid_q;
    logic              d_rvalid_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              i_wins;
    logic              grant_i;
    logic              grant_d;

    // Contention winner: fixed D priority broken by the I starvation limit,
    // or alternation against the last winner.
    always_comb begin
        i_wins = 1'b0;
        if (DBUS_PRIORITY != 0) begin
            i_wins = (wait_cnt_q == WAIT_MAX);
        end else begin
            i_wins = (last_q == LAST_D);
        end
    end

    // A lone requester always wins; D only wins when I does not.
    assign grant_i = i_req && (!d_req || i_wins);
    assign grant_d = d_req && !grant_i;

    generate
        if (DBUS_PRIORITY != 0) begin : g_dbus_prio
            // Counts consecutive cycles I was refused; saturates at the limit.
            always_comb begin
                wait_cnt_d = wait_cnt_q;
                if (!i_req || grant_i) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
        end else begin : g_round_robin
            always_comb begin
                wait_cnt_d = '0;
            end
        end
    endgenerate

    always_comb begin
        last_d = last_q;
        if (grant_i) begin
            last_d = LAST_I;
        end else if (grant_d) begin
            last_d = LAST_D;
        end
    end

    // RAM port follows the winner and is fully zero when idle.
    always_comb begin
        ram_rd_en     = 1'b0;
        ram_wr_en     = 1'b0;
        ram_addr      = '0;
        ram_wr_data   = '0;
        ram_wr_strobe = '0;
        if (grant_i) begin
            ram_rd_en = 1'b1;
            ram_addr  = i_addr;
        end else if (grant_d) begin
            ram_rd_en     = !d_we;
            ram_wr_en     = d_we;
            ram_addr      = d_addr;
            ram_wr_data   = d_wdata;
            ram_wr_strobe = d_strobe;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= LAST_I;
            wait_cnt_q <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
            i_rvalid_q <= grant_i;
            d_rvalid_q <= grant_d;
            if (grant_i) begin
                i_rdata_q <= ram_rd_data;
            end
            // Write acks return zero so stale read data never looks like a response.
            if (grant_d) begin
                d_rdata_q <= d_we ? 32'd0 : ram_rd_data;
            end
        end
    end

    assign i_gnt    = grant_i;
    assign d_gnt    = grant_d;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter. Instance A uses D priority
//            with a byte-lane RAM model; instance B uses round-robin with a
//            fixed address-derived read pattern. Expected responses are queued
//            at issue time and consumed by per-port monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    // Instance A (DBUS_PRIORITY = 1, MAX_WAIT = 4)
    logic          a_i_req, a_i_gnt, a_i_rvalid;
    logic [AW-1:0] a_i_addr;
    logic [31:0]   a_i_rdata;
    logic          a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic [AW-1:0] a_d_addr;
    logic [31:0]   a_d_wdata, a_d_rdata;
    logic [3:0]    a_d_strobe;
    logic          a_ram_rd_en, a_ram_wr_en;
    logic [AW-1:0] a_ram_addr;
    logic [31:0]   a_ram_wr_data, a_ram_rd_data;
    logic [3:0]    a_ram_wr_strobe;

    // Instance B (DBUS_PRIORITY = 0)
    logic          b_i_req, b_i_gnt, b_i_rvalid;
    logic [AW-1:0] b_i_addr;
    logic [31:0]   b_i_rdata;
    logic          b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [AW-1:0] b_d_addr;
    logic [31:0]   b_d_wdata, b_d_rdata;
    logic [3:0]    b_d_strobe;
    logic          b_ram_rd_en, b_ram_wr_en;
    logic [AW-1:0] b_ram_addr;
    logic [31:0]   b_ram_wr_data, b_ram_rd_data;
    logic [3:0]    b_ram_wr_strobe;

    ram_arbiter #(.ADDR_WIDTH(AW), .DBUS_PRIORITY(1), .MAX_WAIT(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_strobe(a_d_strobe),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .ram_rd_en(a_ram_rd_en), .ram_wr_en(a_ram_wr_en), .ram_addr(a_ram_addr),
        .ram_wr_data(a_ram_wr_data), .ram_wr_strobe(a_ram_wr_strobe), .ram_rd_data(a_ram_rd_data)
    );

    ram_arbiter #(.ADDR_WIDTH(AW), .DBUS_PRIORITY(0), .MAX_WAIT(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_strobe(b_d_strobe),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .ram_rd_en(b_ram_rd_en), .ram_wr_en(b_ram_wr_en), .ram_addr(b_ram_addr),
        .ram_wr_data(b_ram_wr_data), .ram_wr_strobe(b_ram_wr_strobe), .ram_rd_data(b_ram_rd_data)
    );

    // RAM model for A: combinational read, byte-lane write at the clock edge.
    logic [31:0] mem [0:(1<<AW)-1];
    assign a_ram_rd_data = mem[a_ram_addr];
    always @(posedge clk) begin
        if (a_ram_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (a_ram_wr_strobe[k]) mem[a_ram_addr][8*k +: 8] <= a_ram_wr_data[8*k +: 8];
            end
        end
    end

    // B only reads; its data is the address tagged with 0xB in the top nibble.
    assign b_ram_rd_data = 32'hB000_0000 | {22'd0, b_ram_addr};

    logic [31:0] q_ai[$];
    logic [31:0] q_ad[$];
    logic [31:0] q_bi[$];
    logic [31:0] q_bd[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Each queued response is due at the first edge after it was issued, so an
    // entry still present then must be matched by rvalid right now.
`define SB_MONITOR(RV, RD, Q, NM) \
    always @(posedge clk) begin \
        #1; \
        if (Q.size() > 0) begin \
            chk({NM, " rvalid"}, {31'd0, RV}, 32'd1); \
            chk({NM, " rdata"}, RD, Q.pop_front()); \
        end else if (RV) begin \
            chk({NM, " unexpected rvalid"}, {31'd0, RV}, 32'd0); \
        end \
    end

    `SB_MONITOR(a_i_rvalid, a_i_rdata, q_ai, "A.I")
    `SB_MONITOR(a_d_rvalid, a_d_rdata, q_ad, "A.D")
    `SB_MONITOR(b_i_rvalid, b_i_rdata, q_bi, "B.I")
    `SB_MONITOR(b_d_rvalid, b_d_rdata, q_bd, "B.D")
`undef SB_MONITOR

    task automatic a_cycle(input logic ir, input logic [AW-1:0] ia,
                           input logic dr, input logic dw, input logic [AW-1:0] da,
                           input logic [31:0] dwd, input logic [3:0] ds,
                           input logic eig, input logic edg,
                           input logic [31:0] eid, input logic [31:0] edd);
        @(negedge clk);
        a_i_req = ir; a_i_addr = ia;
        a_d_req = dr; a_d_we = dw; a_d_addr = da; a_d_wdata = dwd; a_d_strobe = ds;
        #1;
        chk("A i_gnt", {31'd0, a_i_gnt}, {31'd0, eig});
        chk("A d_gnt", {31'd0, a_d_gnt}, {31'd0, edg});
        if (eig) q_ai.push_back(eid);
        if (edg) q_ad.push_back(edd);
    endtask

    task automatic a_idle();
        a_cycle(1'b0, '0, 1'b0, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic b_cycle(input logic ir, input logic dr, input logic eig, input logic edg);
        @(negedge clk);
        b_i_req = ir; b_i_addr = 10'h040;
        b_d_req = dr; b_d_we = 1'b0; b_d_addr = 10'h041; b_d_wdata = 32'd0; b_d_strobe = 4'd0;
        #1;
        chk("B i_gnt", {31'd0, b_i_gnt}, {31'd0, eig});
        chk("B d_gnt", {31'd0, b_d_gnt}, {31'd0, edg});
        if (eig) q_bi.push_back(32'hB000_0040);
        if (edg) q_bd.push_back(32'hB000_0041);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_i_req = 0; a_i_addr = '0; a_d_req = 0; a_d_we = 0; a_d_addr = '0; a_d_wdata = '0; a_d_strobe = '0;
        b_i_req = 0; b_i_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0; b_d_strobe = '0;
        for (int k = 0; k < (1<<AW); k++) mem[k] = 32'h5A00_0000 | k;
        mem[5] = 32'h1122_3344;
        mem[7] = 32'hCAFE_F00D;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("reset i_rvalid", {31'd0, a_i_rvalid}, 32'd0);
        chk("reset d_rvalid", {31'd0, a_d_rvalid}, 32'd0);
        chk("reset i_rdata", a_i_rdata, 32'd0);
        chk("reset d_rdata", a_d_rdata, 32'd0);
        chk("reset ram_rd_en", {31'd0, a_ram_rd_en}, 32'd0);
        chk("reset ram_wr_en", {31'd0, a_ram_wr_en}, 32'd0);
        #2 rst_n = 1'b1;

        // Round-robin from reset: last=I so D first, then alternating
        for (int k = 0; k < 6; k++) b_cycle(1'b1, 1'b1, (k % 2) == 1, (k % 2) == 0);
        b_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // I-only reads of 0x10..0x13 back to back
        for (int k = 0; k < 4; k++) begin
            a_cycle(1'b1, AW'(10'h010 + k), 1'b0, 1'b0, '0, 32'd0, 4'd0,
                    1'b1, 1'b0, 32'h5A00_0010 + k, 32'd0);
            if (k == 0) begin
                chk("I read ram_rd_en", {31'd0, a_ram_rd_en}, 32'd1);
                chk("I read ram_addr", {22'd0, a_ram_addr}, 32'h10);
            end
        end
        a_idle();
        chk("idle ram_addr", {22'd0, a_ram_addr}, 32'd0);
        chk("idle ram_rd_en", {31'd0, a_ram_rd_en}, 32'd0);

        // Partial write then readback
        a_cycle(1'b0, '0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b1, 32'd0, 32'd0);
        chk("write ram_wr_en", {31'd0, a_ram_wr_en}, 32'd1);
        chk("write ram_rd_en", {31'd0, a_ram_rd_en}, 32'd0);
        chk("write ram_addr", {22'd0, a_ram_addr}, 32'd5);
        chk("write ram_wr_data", a_ram_wr_data, 32'hDEAD_BEEF);
        chk("write ram_wr_strobe", {28'd0, a_ram_wr_strobe}, 32'h3);
        a_cycle(1'b0, '0, 1'b1, 1'b0, 10'd5, 32'd0, 4'd0, 1'b0, 1'b1, 32'd0, 32'h1122_BEEF);
        a_idle();

        // Contention under D priority: D,D,D,D,I repeating
        for (int k = 0; k < 12; k++) begin
            a_cycle(1'b1, 10'h030, 1'b1, 1'b0, 10'h020, 32'd0, 4'd0,
                    (k % 5) == 4, (k % 5) != 4, 32'h5A00_0030, 32'h5A00_0020);
            chk("A exclusive gnt", {31'd0, a_i_gnt & a_d_gnt}, 32'd0);
        end
        a_idle();

        // Reset between grant and completion drops the response
        @(negedge clk);
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 10'h021;
        #1 chk("pre-reset d_gnt", {31'd0, a_d_gnt}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset d_rdata", a_d_rdata, 32'd0);
        chk("async reset i_rdata", a_i_rdata, 32'd0);
        chk("async reset d_rvalid", {31'd0, a_d_rvalid}, 32'd0);
        a_d_req = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset d_rvalid", {31'd0, a_d_rvalid}, 32'd0);
        a_cycle(1'b1, 10'h011, 1'b0, 1'b0, '0, 32'd0, 4'd0, 1'b1, 1'b0, 32'h5A00_0011, 32'd0);

        // Zero-strobe write is acked and leaves memory unchanged
        a_cycle(1'b0, '0, 1'b1, 1'b1, 10'd7, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b1, 32'd0, 32'd0);
        a_cycle(1'b0, '0, 1'b1, 1'b0, 10'd7, 32'd0, 4'd0, 1'b0, 1'b1, 32'd0, 32'hCAFE_F00D);
        a_idle();
        a_idle();

        chk("A.I queue drained", q_ai.size(), 32'd0);
        chk("A.D queue drained", q_ad.size(), 32'd0);
        chk("B.I queue drained", q_bi.size(), 32'd0);
        chk("B.D queue drained", q_bd.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
